// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default bus widths, the owner
// tag encoding and the RGB 3:3:3 pixel field layout.
package vram_pkg;

  localparam int AW_DEFAULT = 13;
  localparam int DW_DEFAULT = 9;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_RD   = 2'd2,
    OWN_WR   = 2'd3
  } owner_t;

  // Pixel word is {R[2:0], G[2:0], B[2:0]}.
  localparam int RGB_R_MSB = 8;
  localparam int RGB_R_LSB = 6;
  localparam int RGB_G_MSB = 5;
  localparam int RGB_G_LSB = 3;
  localparam int RGB_B_MSB = 2;
  localparam int RGB_B_LSB = 0;

  function automatic logic [8:0] rgb333(input logic [2:0] r,
                                        input logic [2:0] g,
                                        input logic [2:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VGA/draw clients, the arbiter and the pixel RAM.
// slave is the arbiter's view; master is the client/RAM side.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int LW = 3
);

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_rvalid;

  logic [LW-1:0] fifo_level;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_data, disp_valid,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready, rd_data, rd_rvalid,
    output fifo_level,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_data, disp_valid,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready, rd_data, rd_rvalid,
    input  fifo_level,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// Posted-write FIFO for draw writes. Head entry is visible combinationally so
// a pop can drive the RAM in the same cycle; a push never bypasses to the head.
module vram_wr_fifo #(
  parameter int AW    = 13,
  parameter int DW    = 9,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk25,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int EW = AW + DW;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic          full_reg, empty_reg;
  logic          push_ok, pop_ok;
  logic [EW-1:0] entries [DEPTH];

  assign push_ok = push & ~full_reg;
  assign pop_ok  = pop & ~empty_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [EW-1:0] entry_reg;
      always_ff @(posedge clk25) begin
        if (push_ok && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= {push_addr, push_data};
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      full_reg   <= (level_next == LW'(DEPTH));
      empty_reg  <= (level_next == '0);
    end
  end

  assign {head_addr, head_data} = entries[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;
  assign level = level_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: display fetch always wins, draw writes are
// posted through a small FIFO, draw reads wait until every posted write retired.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk25,
  input  logic          rst,
  vram_arbiter_if.slave bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [LW-1:0] fifo_level;

  owner_t        tag_reg, tag_next;
  logic          mem_en_next;
  logic          mem_we_next;
  logic [AW-1:0] mem_addr_next;
  logic [DW-1:0] mem_wdata_next;

  // full is registered inside the FIFO, so wr_ready reflects the start of cycle.
  assign bus.wr_ready = ~fifo_full & ~rst;
  assign bus.rd_ready = ~bus.disp_req & fifo_empty & ~rst;
  assign fifo_push    = bus.wr_valid & bus.wr_ready;

  vram_wr_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk25     (clk25),
    .rst       (rst),
    .push      (fifo_push),
    .push_addr (bus.wr_addr),
    .push_data (bus.wr_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    tag_next       = OWN_NONE;
    fifo_pop       = 1'b0;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    // Reset blocks every grant so the RAM sees no access while rst is high.
    if (!rst) begin
      if (bus.disp_req) begin
        tag_next = OWN_DISP;
      end else if (!fifo_empty) begin
        tag_next = OWN_WR;
      end else if (bus.rd_valid) begin
        tag_next = OWN_RD;
      end
    end
    unique case (tag_next)
      OWN_DISP: begin
        mem_en_next   = 1'b1;
        mem_addr_next = bus.disp_addr;
      end
      OWN_WR: begin
        fifo_pop       = 1'b1;
        mem_en_next    = 1'b1;
        mem_we_next    = 1'b1;
        mem_addr_next  = head_addr;
        mem_wdata_next = head_data;
      end
      OWN_RD: begin
        mem_en_next   = 1'b1;
        mem_addr_next = bus.rd_addr;
      end
      OWN_NONE: begin
      end
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      tag_reg <= OWN_NONE;
    end else begin
      tag_reg <= tag_next;
    end
  end

  assign bus.mem_en     = mem_en_next;
  assign bus.mem_we     = mem_we_next;
  assign bus.mem_addr   = mem_addr_next;
  assign bus.mem_wdata  = mem_wdata_next;
  assign bus.fifo_level = fifo_level;

  // Both consumers see the raw RAM output; each qualifies it with its own valid.
  assign bus.disp_data  = bus.mem_rdata;
  assign bus.rd_data    = bus.mem_rdata;
  assign bus.disp_valid = (tag_reg == OWN_DISP);
  assign bus.rd_rvalid  = (tag_reg == OWN_RD);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a cycle-by-cycle vector table plus
// hand-written reset, display and reset-mid-drain sequences against a RAM model.
module tb_vram_arbiter;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;
  always #20 clk25 = ~clk25;

  vram_arbiter_if #(.AW(13), .DW(9), .LW(3)) bus ();

  vram_arbiter #(.AW(13), .DW(9), .FIFO_DEPTH(4)) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus)
  );

  // Pixel RAM model: registered read, preloaded with ram[a] = a[8:0].
  logic [8:0] ram [8192];
  bit         ram_init_done = 1'b0;
  always @(posedge clk25) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 9'(i);
      ram_init_done <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        d;
    logic [12:0] da;
    logic        wv;
    logic [12:0] wa;
    logic [8:0]  wd;
    logic        rv;
    logic [12:0] ra;
    logic        en;
    logic        we;
    logic [12:0] ma;
    logic [8:0]  mwd;
    logic        wrdy;
    logic        rrdy;
    logic [2:0]  lvl;
    logic        dv;
    logic        rrv;
    logic [8:0]  rdat;
  } vec_t;

  function automatic vec_t mk(input int d, input int da, input int wv, input int wa,
                              input int wd, input int rv, input int ra, input int en,
                              input int we, input int ma, input int mwd, input int wrdy,
                              input int rrdy, input int lvl, input int dv, input int rrv,
                              input int rdat);
    vec_t v;
    v.d = d[0];     v.da = 13'(da); v.wv = wv[0];   v.wa = 13'(wa); v.wd = 9'(wd);
    v.rv = rv[0];   v.ra = 13'(ra); v.en = en[0];   v.we = we[0];   v.ma = 13'(ma);
    v.mwd = 9'(mwd); v.wrdy = wrdy[0]; v.rrdy = rrdy[0]; v.lvl = 3'(lvl);
    v.dv = dv[0];   v.rrv = rrv[0]; v.rdat = 9'(rdat);
    return v;
  endfunction

  vec_t vecs[25];

  task automatic drive_idle();
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
  endtask

  initial begin
    //          d  da   wv wa   wd     rv ra   en we ma   mwd    wrdy rrdy lvl dv rrv rdat
    // Writes posted under active video, then drained when display goes idle.
    vecs[0]  = mk(1, 200, 1, 100, 'h1FF, 0, 0,  1, 0, 200, 0,     1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 201, 1, 101, 'h1FE, 0, 0,  1, 0, 201, 0,     1, 0, 1, 1, 0, 200);
    vecs[2]  = mk(1, 202, 1, 102, 'h1FD, 0, 0,  1, 0, 202, 0,     1, 0, 2, 1, 0, 201);
    vecs[3]  = mk(1, 203, 1, 103, 'h1FC, 0, 0,  1, 0, 203, 0,     1, 0, 3, 1, 0, 202);
    vecs[4]  = mk(1, 204, 0, 0,   0,     0, 0,  1, 0, 204, 0,     0, 0, 4, 1, 0, 203);
    vecs[5]  = mk(0, 0,   0, 0,   0,     0, 0,  1, 1, 100, 'h1FF, 0, 0, 4, 1, 0, 204);
    vecs[6]  = mk(0, 0,   0, 0,   0,     0, 0,  1, 1, 101, 'h1FE, 1, 0, 3, 0, 0, 0);
    vecs[7]  = mk(0, 0,   0, 0,   0,     0, 0,  1, 1, 102, 'h1FD, 1, 0, 2, 0, 0, 0);
    vecs[8]  = mk(0, 0,   0, 0,   0,     0, 0,  1, 1, 103, 'h1FC, 1, 0, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0,   0, 0,   0,     0, 0,  0, 0, 0,   0,     1, 1, 0, 0, 0, 0);
    vecs[10] = mk(1, 100, 0, 0,   0,     0, 0,  1, 0, 100, 0,     1, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 103, 0, 0,   0,     0, 0,  1, 0, 103, 0,     1, 0, 0, 1, 0, 'h1FF);
    vecs[12] = mk(0, 0,   0, 0,   0,     0, 0,  0, 0, 0,   0,     1, 1, 0, 1, 0, 'h1FC);
    // Read-after-write ordering on address 50.
    vecs[13] = mk(0, 0,   1, 50,  'h0AA, 0, 0,  0, 0, 0,   0,     1, 1, 0, 0, 0, 0);
    vecs[14] = mk(0, 0,   0, 0,   0,     1, 50, 1, 1, 50,  'h0AA, 1, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 0,   0, 0,   0,     1, 50, 1, 0, 50,  0,     1, 1, 0, 0, 0, 0);
    vecs[16] = mk(0, 0,   0, 0,   0,     0, 0,  0, 0, 0,   0,     1, 1, 0, 0, 1, 'h0AA);
    // Simultaneous push and pop.
    vecs[17] = mk(0, 0,   1, 60,  'h011, 0, 0,  0, 0, 0,   0,     1, 1, 0, 0, 0, 0);
    vecs[18] = mk(0, 0,   1, 61,  'h022, 0, 0,  1, 1, 60,  'h011, 1, 0, 1, 0, 0, 0);
    vecs[19] = mk(0, 0,   0, 0,   0,     0, 0,  1, 1, 61,  'h022, 1, 0, 1, 0, 0, 0);
    // Priority collision: DISP, then WR, then RD.
    vecs[20] = mk(0, 0,   1, 70,  'h033, 0, 0,  0, 0, 0,   0,     1, 1, 0, 0, 0, 0);
    vecs[21] = mk(1, 5,   0, 0,   0,     1, 61, 1, 0, 5,   0,     1, 0, 1, 0, 0, 0);
    vecs[22] = mk(0, 0,   0, 0,   0,     1, 61, 1, 1, 70,  'h033, 1, 0, 1, 1, 0, 5);
    vecs[23] = mk(0, 0,   0, 0,   0,     1, 61, 1, 0, 61,  0,     1, 1, 0, 0, 0, 0);
    vecs[24] = mk(0, 0,   0, 0,   0,     0, 0,  0, 0, 0,   0,     1, 1, 0, 0, 1, 'h022);

    // Reset held with requests pending: no RAM access, all status quiet.
    drive_idle();
    bus.disp_req = 1'b1;
    bus.rd_valid = 1'b1;
    repeat (3) @(posedge clk25);
    @(negedge clk25);
    chk("rst_mem_en", 0, 32'(bus.mem_en), 0);
    chk("rst_wr_ready", 0, 32'(bus.wr_ready), 0);
    chk("rst_rd_ready", 0, 32'(bus.rd_ready), 0);
    chk("rst_level", 0, 32'(bus.fifo_level), 0);
    chk("rst_disp_valid", 0, 32'(bus.disp_valid), 0);
    chk("rst_rd_rvalid", 0, 32'(bus.rd_rvalid), 0);
    $display("reset: mem_en=%0b wr_ready=%0b level=%0d", bus.mem_en, bus.wr_ready, bus.fifo_level);

    @(posedge clk25); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk25);
    chk("rel_wr_ready", 0, 32'(bus.wr_ready), 1);
    chk("rel_rd_ready", 0, 32'(bus.rd_ready), 1);
    chk("rel_level", 0, 32'(bus.fifo_level), 0);
    chk("rel_disp_valid", 0, 32'(bus.disp_valid), 0);
    $display("release: wr_ready=%0b rd_ready=%0b", bus.wr_ready, bus.rd_ready);

    // Display-only burst over addresses 0..9.
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk25); #1;
      bus.disp_req  = (i < 10);
      bus.disp_addr = 13'(i);
      @(negedge clk25);
      if (i < 10) begin
        chk("disp_mem_en", i, 32'(bus.mem_en), 1);
        chk("disp_mem_addr", i, 32'(bus.mem_addr), 32'(i));
      end else begin
        chk("disp_mem_en", i, 32'(bus.mem_en), 0);
      end
      chk("disp_mem_we", i, 32'(bus.mem_we), 0);
      if (i > 0) begin
        chk("disp_valid", i, 32'(bus.disp_valid), 1);
        chk("disp_data", i, 32'(bus.disp_data), 32'(i - 1));
      end
      $display("disp %0d: en=%0b addr=%0d valid=%0b data=%0h", i, bus.mem_en,
               bus.mem_addr, bus.disp_valid, bus.disp_data);
    end

    // Table-driven cycles.
    for (int k = 0; k < 25; k++) begin
      @(posedge clk25); #1;
      bus.disp_req = vecs[k].d;  bus.disp_addr = vecs[k].da;
      bus.wr_valid = vecs[k].wv; bus.wr_addr = vecs[k].wa; bus.wr_data = vecs[k].wd;
      bus.rd_valid = vecs[k].rv; bus.rd_addr = vecs[k].ra;
      @(negedge clk25);
      chk("mem_en", k, 32'(bus.mem_en), 32'(vecs[k].en));
      chk("mem_we", k, 32'(bus.mem_we), 32'(vecs[k].we));
      chk("mem_addr", k, 32'(bus.mem_addr), 32'(vecs[k].ma));
      chk("mem_wdata", k, 32'(bus.mem_wdata), 32'(vecs[k].mwd));
      chk("wr_ready", k, 32'(bus.wr_ready), 32'(vecs[k].wrdy));
      chk("rd_ready", k, 32'(bus.rd_ready), 32'(vecs[k].rrdy));
      chk("fifo_level", k, 32'(bus.fifo_level), 32'(vecs[k].lvl));
      chk("disp_valid", k, 32'(bus.disp_valid), 32'(vecs[k].dv));
      chk("rd_rvalid", k, 32'(bus.rd_rvalid), 32'(vecs[k].rrv));
      if (vecs[k].dv) chk("disp_data", k, 32'(bus.disp_data), 32'(vecs[k].rdat));
      if (vecs[k].rrv) chk("rd_data", k, 32'(bus.rd_data), 32'(vecs[k].rdat));
      $display("vec %0d: d=%0b wv=%0b rv=%0b -> en=%0b we=%0b addr=%0d lvl=%0d dv=%0b rrv=%0b",
               k, vecs[k].d, vecs[k].wv, vecs[k].rv, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.fifo_level, bus.disp_valid, bus.rd_rvalid);
    end

    // Reset mid-drain: queue 80..82 under display, start a pop, hit rst.
    for (int j = 0; j < 3; j++) begin
      @(posedge clk25); #1;
      drive_idle();
      bus.disp_req = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 13'(80 + j);
      bus.wr_data  = 9'(9'h101 + j);
      @(negedge clk25);
      $display("queue %0d: level=%0d wr_ready=%0b", j, bus.fifo_level, bus.wr_ready);
    end
    @(posedge clk25); #1;
    drive_idle();
    @(negedge clk25);
    chk("drain_level", 0, 32'(bus.fifo_level), 3);
    chk("drain_we", 0, 32'(bus.mem_we), 1);
    chk("drain_addr", 0, 32'(bus.mem_addr), 80);
    chk("drain_disp_valid", 0, 32'(bus.disp_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_en", 0, 32'(bus.mem_en), 0);
    chk("mid_rst_level", 0, 32'(bus.fifo_level), 0);
    chk("mid_rst_disp_valid", 0, 32'(bus.disp_valid), 0);
    chk("mid_rst_rd_rvalid", 0, 32'(bus.rd_rvalid), 0);
    $display("mid-drain reset: en=%0b level=%0d dv=%0b", bus.mem_en, bus.fifo_level,
             bus.disp_valid);
    @(posedge clk25); #1;
    rst = 1'b0;
    // Read back the queued addresses: all must still hold their preload values.
    for (int j = 0; j <= 3; j++) begin
      if (j > 0) begin
        @(posedge clk25); #1;
      end
      bus.disp_req  = (j < 3);
      bus.disp_addr = 13'(80 + j);
      @(negedge clk25);
      chk("post_rst_level", j, 32'(bus.fifo_level), 0);
      chk("post_rst_rd_rvalid", j, 32'(bus.rd_rvalid), 0);
      if (j == 0) begin
        chk("post_rst_disp_valid", j, 32'(bus.disp_valid), 0);
      end else begin
        chk("post_rst_disp_valid", j, 32'(bus.disp_valid), 1);
        chk("post_rst_ram", j, 32'(bus.disp_data), 32'(80 + j - 1));
      end
      $display("readback %0d: valid=%0b data=%0h", j, bus.disp_valid, bus.disp_data);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port pixel RAM (13-bit address, 9-bit RGB 3:3:3 data) between two requesters.
- The VGA display fetch path always has absolute priority. The drawing client (sprite/movement logic) gets posted writes and non-posted reads.
- Runs in the 25 MHz pixel clock domain, between the VGA timing module and the pixel memory.
- Draw writes are buffered in a small FIFO, so drawing can proceed during active video and retire in blanking or idle cycles.

Parameters:
- AW, 13, address width.
- DW, 9, pixel data width.
- FIFO_DEPTH, 4, write-post FIFO entries; power of two, ≥2.

Ports:
- clk25  in  1  pixel clock, 25 MHz.
- rst  in  1  asynchronous reset, active-high.
- disp_req  in  1  display wants a pixel read this cycle.
- disp_addr  in  AW  display read address.
- disp_data  out  DW  display read data.
- disp_valid  out  1  disp_data valid; 1 cycle after a granted disp_req.
- wr_valid  in  1  draw write request.
- wr_ready  out  1  write accepted when wr_valid&wr_ready.
- wr_addr  in  AW  draw write address.
- wr_data  in  DW  draw write data.
- rd_valid  in  1  draw read request.
- rd_ready  out  1  read accepted when rd_valid&rd_ready.
- rd_addr  in  AW  draw read address.
- rd_data  out  DW  draw read data.
- rd_rvalid  out  1  rd_data valid, 1-cycle pulse.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; registered, 1-cycle latency.

Behaviour:
- Reset values:
  - disp_valid=0, rd_rvalid=0, fifo_level=0.
  - wr_ready=1 after reset releases (0 while rst is high).
  - Owner tag = NONE.
  - FIFO pointers = 0.
- Port grant is decided combinationally each cycle, in strict priority order:
  1. DISP: disp_req=1. Then mem_en=1, mem_we=0, mem_addr=disp_addr.
  2. WR: disp_req=0 and FIFO not empty. Pop the head, mem_en=1, mem_we=1, head addr/data drive the RAM.
  3. RD: disp_req=0, FIFO empty, rd_valid=1. Then rd_ready=1, mem_en=1, mem_we=0, mem_addr=rd_addr.
  4. NONE: mem_en=0, mem_we=0, mem_addr/mem_wdata hold 0.
- rd_ready is combinational: !disp_req & (fifo empty) & !rst. This keeps read-after-write ordering: a draw read never bypasses a posted write.
- wr_ready is registered: 1 when the FIFO is not full at the start of the cycle.
  - A push while full is impossible.
  - Push and pop in the same cycle are both allowed when not full; level is unchanged.
- Owner tag register records the grant (DISP/RD/other) for the next cycle.
  - disp_valid = (tag==DISP); rd_rvalid = (tag==RD).
  - disp_data and rd_data both pass mem_rdata straight through. Consumers qualify the data with their own valid.
- Latency:
  - Display read: exactly 1 cycle, never stalled.
  - Draw read: 1 cycle after acceptance.
  - Posted write: retires on the first non-display cycle when it reaches the FIFO head.
  - Minimum write retire latency: 1 cycle after push when the FIFO was empty.
- A write pushed this cycle cannot pop in the same cycle; the FIFO has no bypass.
- Continuous disp_req starves the draw client indefinitely. This is intended: horizontal and vertical blanking give the drain windows.
- Pointer arithmetic wraps modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH.
- Asserting rst mid-operation:
  - Pending FIFO writes are discarded.
  - Any in-flight read response is dropped (disp_valid/rd_rvalid forced 0).
  - The RAM sees mem_en=0 from the cycle rst asserts.

Decomposition:
- Shared package vram_pkg holds:
  - AW, DW defaults.
  - Owner tag encoding (NONE=2'd0, DISP=2'd1, RD=2'd2, WR=2'd3).
  - The RGB 3:3:3 field slicing constants.
- One sub-module: vram_wr_fifo. It is a synchronous FIFO with push/pop/full/empty/level, storing {addr,data}, with asynchronous active-high reset on its pointers.
- The arbiter top keeps the grant logic and the owner tag.

Test Plan:
- Display only: disp_req=1 for addresses 0..9 with the RAM preloaded to addr[8:0]. Expect disp_valid=1 one cycle later, disp_data=0..9 in order, and mem_we never 1.
- Write under active video: disp_req=1 held, push 4 writes (addr 100..103, data 9'h1FF..9'h1FC). Expect wr_ready=0 after the 4th push and fifo_level=4. Drop disp_req: writes retire on 4 consecutive cycles in order and fifo_level returns to 0.
- Read ordering: push write addr 50 data 9'h0AA, then immediately issue a read of addr 50. Expect rd_ready=0 until the FIFO is empty, then rd_rvalid with rd_data=9'h0AA.
- Simultaneous push/pop: disp_req=0, one entry in the FIFO, and wr_valid with a new entry in the same cycle. Expect the level to stay at 1 and wr_ready to stay 1.
- Priority collision: disp_req, a FIFO entry and rd_valid all asserted together. The cycle grants DISP, the next cycle WR, then RD, with matching valid pulses.
- Reset mid-drain: 3 entries queued, pulse rst during a pop. Expect mem_en=0 immediately, fifo_level=0, no rd_rvalid/disp_valid, and RAM contents at the un-popped addresses unchanged.
